// File: rtl/spi_frame_rx_if.sv
// spi_frame_rx_if: pad-side serial pins plus core-side rx/tx handshakes of the SPI framing stage.
interface spi_frame_rx_if #(
   parameter int CMD_W  = 8,
   parameter int WORD_W = 32
);
   logic              cs_n;
   logic              sdi;
   logic              sdo;
   logic [CMD_W-1:0]  rx_cmd;
   logic              rx_cmd_valid;
   logic [WORD_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic [WORD_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              frame_err;
   modport slave (
      input  cs_n, sdi, rx_ready, tx_data, tx_valid,
      output sdo, rx_cmd, rx_cmd_valid, rx_data, rx_valid, tx_ready, frame_err
   );
   modport master (
      output cs_n, sdi, rx_ready, tx_data, tx_valid,
      input  sdo, rx_cmd, rx_cmd_valid, rx_data, rx_valid, tx_ready, frame_err
   );
endinterface

// File: rtl/spi_frame_rx.sv
// spi_frame_rx: SPI slave framer, command byte then back-to-back payload words in (write) or out (read).
module spi_frame_rx #(
   parameter int CMD_W  = 8,
   parameter int WORD_W = 32
) (
   input logic           interface_clk,
   input logic           reset_n,
   spi_frame_rx_if.slave bus
);
   localparam int CW = $clog2(WORD_W);
   typedef enum logic [1:0] {IDLE, CMD, RDATA, TDATA} state_t;
   state_t            state, state_nx;
   logic [CW-1:0]     cnt;
   logic [CMD_W-2:0]  cmd_sh;
   logic [WORD_W-2:0] sh;
   logic              cmd_done, word_done, is_rd, load_pt;
   always_ff @(posedge interface_clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   always_comb begin
      cmd_done  = state == CMD && cnt == CW'(CMD_W - 1);
      word_done = cnt == CW'(WORD_W - 1);
      is_rd     = cmd_sh[CMD_W-2];
      // a read response word is fetched when the command completes and at every word boundary after
      load_pt   = !bus.cs_n && ((cmd_done && is_rd) || (state == TDATA && word_done));
      bus.tx_ready = load_pt && bus.tx_valid;
      state_nx  = bus.cs_n       ? IDLE :
                  state == IDLE  ? CMD :
                  cmd_done       ? (is_rd ? TDATA : RDATA) : state;
   end
   always_ff @(posedge interface_clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt              <= '0;
         cmd_sh           <= '0;
         sh               <= '0;
         bus.sdo          <= 1'b0;
         bus.rx_cmd       <= '0;
         bus.rx_cmd_valid <= 1'b0;
         bus.rx_data      <= '0;
         bus.rx_valid     <= 1'b0;
         bus.frame_err    <= 1'b0;
      end else begin
         bus.rx_cmd_valid <= 1'b0;
         if (bus.rx_ready) bus.rx_valid <= 1'b0;
         if (bus.cs_n) begin
            cnt     <= '0;
            bus.sdo <= 1'b0;
            if (state == CMD || cnt != '0) bus.frame_err <= 1'b1;
         end else begin
            cnt <= state == IDLE ? CW'(1) : (cmd_done || word_done) ? '0 : cnt + CW'(1);
            if (state == IDLE) bus.frame_err <= 1'b0;
            if (state == IDLE || state == CMD) cmd_sh <= {cmd_sh[CMD_W-3:0], bus.sdi};
            if (cmd_done) begin
               bus.rx_cmd       <= {cmd_sh, bus.sdi};
               bus.rx_cmd_valid <= 1'b1;
            end
            if (load_pt) begin
               sh      <= bus.tx_valid ? bus.tx_data[WORD_W-2:0] : '0;
               bus.sdo <= bus.tx_valid & bus.tx_data[WORD_W-1];
               if (!bus.tx_valid) bus.frame_err <= 1'b1;
            end else begin
               sh      <= {sh[WORD_W-3:0], state == RDATA && bus.sdi};
               bus.sdo <= state == TDATA && sh[WORD_W-2];
            end
            if (state == RDATA && word_done) begin
               if (!bus.rx_valid || bus.rx_ready) begin
                  bus.rx_data  <= {sh, bus.sdi};
                  bus.rx_valid <= 1'b1;
               end else bus.frame_err <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_spi_frame_rx.sv
// tb_spi_frame_rx: frame-level reference model against the SPI framer, directed plus randomized frames.
module tb_spi_frame_rx;
   logic interface_clk = 1'b0;
   logic reset_n = 1'b1;
   spi_frame_rx_if bus();
   spi_frame_rx dut (.interface_clk(interface_clk), .reset_n(reset_n), .bus(bus));
   always #5 interface_clk = ~interface_clk;
   int checks = 0;
   int errors = 0;
   logic [7:0]  got_cmd[$];
   logic [31:0] got_rx[$];
   logic [31:0] pay_q[$];
   logic [31:0] tx_q[$];
   logic        sdo_bits[$];
   int          txr_cnt, rxv_cnt;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic chk_rst();
      check("rst_sdo", bus.sdo, 0);
      check("rst_cmd", bus.rx_cmd, 0);
      check("rst_cmdv", bus.rx_cmd_valid, 0);
      check("rst_data", bus.rx_data, 0);
      check("rst_valid", bus.rx_valid, 0);
      check("rst_err", bus.frame_err, 0);
      check("rst_txr", bus.tx_ready, 0);
   endtask
   // one host clock: drive, look at tx_ready before the edge, observe everything after it
   task automatic clk_bit(input logic cs, input logic d);
      logic tr;
      bus.cs_n = cs;
      bus.sdi  = d;
      #1 tr = bus.tx_ready;
      @(posedge interface_clk);
      #1;
      if (tr) begin
         txr_cnt++;
         if (tx_q.size() > 0) tx_q.delete(0);
         bus.tx_data = tx_q.size() > 0 ? tx_q[0] : 32'h0;
      end
      if (bus.rx_cmd_valid) got_cmd.push_back(bus.rx_cmd);
      if (bus.rx_valid) rxv_cnt++;
      if (bus.rx_valid && bus.rx_ready) got_rx.push_back(bus.rx_data);
      sdo_bits.push_back(bus.sdo);
   endtask
   task automatic frame(input logic [7:0] cmd, input int nbits);
      logic rd;
      int nw;
      logic [31:0] w, obs;
      rd = cmd[7];
      nw = nbits / 32;
      got_cmd.delete(); got_rx.delete(); sdo_bits.delete();
      txr_cnt = 0; rxv_cnt = 0;
      tx_q = pay_q;
      bus.tx_data = tx_q.size() > 0 ? tx_q[0] : 32'h0;
      for (int i = 0; i < 8; i++) begin
         clk_bit(1'b0, cmd[7-i]);
         if (i == 0) check("err_clr", bus.frame_err, 0);
      end
      for (int j = 0; j < nbits; j++) begin
         w = pay_q[j/32];
         clk_bit(1'b0, w[31-j%32]);
      end
      clk_bit(1'b1, 1'b0);
      check("sdo_idle", bus.sdo, 0);
      check("cmd_n", got_cmd.size(), 1);
      if (got_cmd.size() > 0) check("cmd", got_cmd[0], cmd);
      if (rd) begin
         check("txr_n", txr_cnt, bus.tx_valid ? nw + 1 : 0);
         for (int k = 0; k < nw; k++) begin
            obs = 0;
            for (int b = 0; b < 32; b++) obs = {obs[30:0], sdo_bits[7 + 32*k + b]};
            check("sdo_word", obs, bus.tx_valid ? pay_q[k] : 32'h0);
         end
         check("rx_n", got_rx.size(), 0);
      end else begin
         check("rx_n", got_rx.size(), bus.rx_ready ? nw : 0);
         for (int k = 0; k < got_rx.size() && k < nw; k++) check("rx_word", got_rx[k], pay_q[k]);
         if (bus.rx_ready) check("rxv_cyc", rxv_cnt, nw);
      end
      check("frame_err", bus.frame_err,
            (nbits % 32 != 0) || (rd && !bus.tx_valid) || (!rd && !bus.rx_ready && nw >= 2));
   endtask
   initial begin
      logic rd;
      int nbits;
      logic [31:0] w;
      bus.cs_n = 1'b1; bus.sdi = 1'b0; bus.rx_ready = 1'b1;
      bus.tx_valid = 1'b0; bus.tx_data = 32'h0;
      #2 reset_n = 1'b0;
      repeat (3) @(posedge interface_clk);
      #1 chk_rst();
      reset_n = 1'b1;
      clk_bit(1'b1, 1'b0);
      clk_bit(1'b1, 1'b0);
      pay_q = '{32'hDEADBEEF};
      frame(8'h01, 32);
      bus.tx_valid = 1'b1;
      pay_q = '{32'hCAFEF00D, $urandom};
      frame(8'h80, 32);
      bus.rx_ready = 1'b0;
      pay_q = '{32'h11111111, 32'h22222222};
      frame(8'h00, 64);
      check("ovr_valid", bus.rx_valid, 1);
      check("ovr_data", bus.rx_data, 32'h11111111);
      bus.rx_ready = 1'b1;
      clk_bit(1'b1, 1'b0);
      check("ovr_drop", bus.rx_valid, 0);
      pay_q = '{$urandom};
      frame(8'h02, 13);
      bus.tx_valid = 1'b0;
      pay_q = '{32'h0};
      frame(8'h81, 32);
      for (int n = 0; n < 24; n++) begin
         rd = 1'($urandom % 2);
         nbits = ($urandom % 4 == 0) ? int'($urandom_range(1, 95)) : 32 * int'($urandom_range(1, 3));
         pay_q.delete();
         for (int i = 0; i < 4; i++) pay_q.push_back($urandom);
         bus.tx_valid = rd && ($urandom % 5 != 0);
         frame({rd, 7'($urandom)}, nbits);
      end
      w = $urandom;
      for (int i = 0; i < 8; i++) clk_bit(1'b0, 1'b0);
      for (int i = 0; i < 20; i++) clk_bit(1'b0, w[31-i]);
      bus.cs_n = 1'b1;
      #2 reset_n = 1'b0;
      #1 chk_rst();
      clk_bit(1'b1, 1'b0);
      clk_bit(1'b1, 1'b0);
      chk_rst();
      reset_n = 1'b1;
      clk_bit(1'b1, 1'b0);
      pay_q = '{32'h0000A5A5};
      frame(8'h00, 32);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/spi_frame_rx.md
Name: spi_frame_rx

Overview:
SPI slave framing stage that sits directly downstream of the pad ring. It consumes die_cs_n and die_sdi in the interface_clk domain and drives die_sdo. Each chip-select frame is deserialised into one command byte followed by 32-bit payload words, presented to the core-side CDC FIFO over a valid/ready handshake. On read commands it serialises response words from the core back out on sdo.

Parameters:
CMD_W, 8, command field width in bits, MSB first. Bit CMD_W-1 = 1 marks a read command.
WORD_W, 32, payload and response word width in bits, MSB first.

Ports:
interface_clk  input  1  SPI clock. Free-running. All state updates on its rising edge.
reset_n  input  1  Asynchronous, active-low reset.
cs_n  input  1  Frame enable, active low, from the die_cs_n pad.
sdi  input  1  Serial data in, sampled on rising edge while cs_n=0.
sdo  output  1  Serial data out, registered, to the die_sdo pad.
rx_cmd  output  CMD_W  Last received command byte.
rx_cmd_valid  output  1  One-cycle pulse when rx_cmd is updated.
rx_data  output  WORD_W  Received payload word.
rx_valid  output  1  rx_data is valid; held until it is accepted.
rx_ready  input  1  Core side accepts rx_data.
tx_data  input  WORD_W  Response word from the core.
tx_valid  input  1  tx_data is available.
tx_ready  output  1  Combinational. High in the cycle tx_data is loaded.
frame_err  output  1  Sticky frame error flag.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, all counters 0.
  - sdo=0, rx_cmd=0, rx_cmd_valid=0, rx_data=0, rx_valid=0, frame_err=0.
  - tx_ready=0, because it is combinational from state.
- States: IDLE, CMD, RDATA (write payload), TDATA (read payload).
- IDLE:
  - On an edge with cs_n=0: go to CMD.
  - The bit sampled at that edge counts as command bit 0.
  - frame_err clears at that same edge.
- CMD:
  - Shift sdi into the command register, MSB first.
  - At the edge sampling bit CMD_W-1: rx_cmd loads, and rx_cmd_valid=1 for the following cycle only.
  - Next state is TDATA if the command MSB is 1, otherwise RDATA. The bit counter resets to 0.
- RDATA:
  - Shift sdi, MSB first.
  - At the edge sampling bit WORD_W-1, there are two cases:
    - If rx_valid=0, or rx_valid=1 with rx_ready=1 at that edge: load rx_data and set rx_valid=1.
    - Otherwise (overrun): drop the word and set frame_err=1.
  - rx_valid clears on any edge with rx_ready=1, unless a new word loads at the same edge.
  - Latency: rx_valid is high in the cycle after the last bit is sampled.
- TDATA:
  - The load point is the edge that completes the command, and every WORD_W-th edge after it.
  - At a load point with tx_valid=1: tx_ready=1 in that cycle, the shift register loads tx_data, and sdo takes tx_data[WORD_W-1] after that edge.
  - At a load point with tx_valid=0 (underrun): the shift register loads 0 and frame_err=1.
  - Between load points: shift left 1 per edge; sdo = shift[MSB].
  - The host samples sdo on the next rising edge, so response bit 0 is sampled at the edge after the load.
  - sdi is ignored in TDATA.
- cs_n high on any edge, from any state:
  - Go to IDLE and force sdo=0.
  - Discard any partial word or command.
  - If the state was CMD, or the bit counter was nonzero, set frame_err=1.
  - rx_valid and rx_data are unaffected; a pending word is still handed off.
- sdo is 0 whenever the state is not TDATA.
- Counters wrap at WORD_W with no gap. Back-to-back words need no idle bits.
- Reset asserted mid-frame aborts immediately to reset values. No partial output is produced.

Test Plan:
- Write frame:
  - Stimulus: cs_n low; 8 bits of 0x01, then 32 bits of 0xDEADBEEF; rx_ready held 1; then cs_n high.
  - Response: rx_cmd=0x01 with a 1-cycle rx_cmd_valid; rx_data=0xDEADBEEF with rx_valid high for exactly 1 cycle; frame_err=0.
- Read frame:
  - Stimulus: command 0x80, tx_valid=1, tx_data=0xCAFEF00D, then 32 more clocks.
  - Response: tx_ready pulses at the command-completing edge; the 32 bits sampled on sdo equal 0xCAFEF00D MSB first; frame_err=0.
- Overrun:
  - Stimulus: write frame with words 0x11111111 and 0x22222222 back-to-back, rx_ready=0 throughout.
  - Response: rx_data stays 0x11111111 with rx_valid held; frame_err=1 after the 2nd word; raising rx_ready later drops rx_valid.
- Short frame:
  - Stimulus: command 0x02, then 13 payload bits, then cs_n high.
  - Response: no rx_valid; frame_err=1; state returns to IDLE.
  - Follow-up: the next frame's first cs_n-low edge clears frame_err.
- Underrun:
  - Stimulus: read command 0x81 with tx_valid=0.
  - Response: sdo reads 32 zeros; tx_ready never asserts; frame_err=1.
- Reset mid-frame:
  - Stimulus: reset_n low after 20 bits of a write word, then released, then a clean write frame with 0x0000A5A5.
  - Response: all outputs are at reset values while reset_n is low; the clean frame delivers rx_data=0x0000A5A5 and no stale bits.
